// File: rtl/dmem_access_arbiter_if.sv
// dmem_access_arbiter_if: CPU, loader and memory-port signals of the data memory arbiter
interface dmem_access_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              cpu_misalign;
  logic              ldr_req;
  logic              ldr_we;
  logic              ldr_lock;
  logic [ADDR_W-1:0] ldr_addr;
  logic [31:0]       ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [31:0]       ldr_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_maskByte;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_misalign,
    input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_read, mem_write, mem_address, mem_maskByte, mem_write_data,
    input  mem_read_data
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_misalign,
    output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_read, mem_write, mem_address, mem_maskByte, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: arbitrates the data memory port between CPU and loader with lane masking and load extension
module dmem_access_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_access_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          cpu_rv_q, mis_q, uns_q, ldr_rv_q;
  logic [1:0]    off_q, size_q;
  logic [31:0]   word_q;
  logic [1:0]    off;
  logic [3:0]    cpu_mask;
  logic          mis, lock_hold, cpu_gnt, ldr_gnt, cpu_go, mem_rd, mem_wr;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ext;
  // arbitration, next state, alignment decode and memory port drive
  always_comb begin
    off       = bus.cpu_addr[1:0];
    cpu_mask  = bus.cpu_size == 2'b00 ? 4'b0001 << off :
                bus.cpu_size == 2'b01 ? (off == 2'd0 ? 4'b0011 : off == 2'd2 ? 4'b1100 : 4'b0000) :
                (bus.cpu_size == 2'b10 && off == 2'd0) ? 4'b1111 : 4'b0000;
    mis       = cpu_mask == 4'b0000;
    lock_hold = state_q == LOCKED && bus.ldr_lock;
    ldr_gnt   = rst && bus.ldr_req && (lock_hold || !bus.cpu_req || starve_q == SW'(STARVE_MAX));
    cpu_gnt   = rst && bus.cpu_req && !lock_hold && !ldr_gnt;
    cpu_go    = cpu_gnt && !mis;
    mem_rd    = (cpu_go && !bus.cpu_we) || (ldr_gnt && !bus.ldr_we);
    mem_wr    = (cpu_go && bus.cpu_we) || (ldr_gnt && bus.ldr_we);
    state_d   = ((ldr_gnt && bus.ldr_lock) || lock_hold) ? LOCKED : ARB;
    starve_d  = (ldr_gnt || !bus.ldr_req) ? '0 :
                (cpu_gnt && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
  end
  assign bus.cpu_gnt        = cpu_gnt;
  assign bus.ldr_gnt        = ldr_gnt;
  assign bus.mem_read       = mem_rd;
  assign bus.mem_write      = mem_wr;
  assign bus.mem_address    = cpu_go ? bus.cpu_addr[ADDR_W+1:2] : ldr_gnt ? bus.ldr_addr : '0;
  assign bus.mem_maskByte   = cpu_go ? cpu_mask : ldr_gnt ? 4'b1111 : 4'b0000;
  assign bus.mem_write_data = cpu_go ? bus.cpu_wdata : ldr_gnt ? bus.ldr_wdata : '0;
  // ownership state and loader starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
  // capture the read word and response context on the grant edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rv_q <= 1'b0;
      mis_q    <= 1'b0;
      uns_q    <= 1'b0;
      ldr_rv_q <= 1'b0;
      off_q    <= '0;
      size_q   <= '0;
      word_q   <= '0;
    end else begin
      cpu_rv_q <= cpu_gnt && (mis || !bus.cpu_we);
      mis_q    <= cpu_gnt && mis;
      uns_q    <= bus.cpu_unsigned;
      ldr_rv_q <= ldr_gnt && !bus.ldr_we;
      off_q    <= off;
      size_q   <= bus.cpu_size;
      word_q   <= mem_rd ? bus.mem_read_data : word_q;
    end
  end
  // lane extraction and sign/zero extension of the captured word
  always_comb begin
    byte_v = word_q[8*off_q +: 8];
    half_v = word_q[16*off_q[1] +: 16];
    ext    = size_q == 2'b00 ? {{24{~uns_q & byte_v[7]}}, byte_v} :
             size_q == 2'b01 ? {{16{~uns_q & half_v[15]}}, half_v} : word_q;
  end
  assign bus.cpu_rvalid   = cpu_rv_q;
  assign bus.cpu_misalign = mis_q;
  assign bus.cpu_rdata    = (cpu_rv_q && !mis_q) ? ext : '0;
  assign bus.ldr_rvalid   = ldr_rv_q;
  assign bus.ldr_rdata    = ldr_rv_q ? word_q : '0;
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb_dmem_access_arbiter: directed checks of arbitration, masking, extension, locking and reset
module tb_dmem_access_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  dmem_access_arbiter_if #(.ADDR_W(30)) bus_if ();
  dmem_access_arbiter #(.ADDR_W(30), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus_if));
  logic [31:0] ld_addr [6] = '{32'h6, 32'h1, 32'h1, 32'h3, 32'h0, 32'h10C};
  logic [1:0]  ld_size [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
  logic        ld_uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] ld_word [6] = '{32'h8001_1234, 32'h0000_F200, 32'h0000_F200, 32'h7F00_0000, 32'h0000_8001, 32'hDEAD_BEEF};
  logic [3:0]  ld_mask [6] = '{4'b1100, 4'b0010, 4'b0010, 4'b1000, 4'b0011, 4'b1111};
  logic [31:0] ld_exp  [6] = '{32'hFFFF_8001, 32'h0000_00F2, 32'hFFFF_FFF2, 32'h0000_007F, 32'h0000_8001, 32'hDEAD_BEEF};
  logic [31:0] ma_addr [4] = '{32'h2, 32'h1, 32'h0, 32'h3};
  logic [1:0]  ma_size [4] = '{2'b10, 2'b01, 2'b11, 2'b01};
  logic        ma_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] bb_addr [4] = '{32'h0, 32'h2, 32'h2, 32'h4};
  logic [1:0]  bb_size [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
  logic        bb_uns  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] bb_word [4] = '{32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'hCAFE_F00D};
  logic [31:0] bb_exp  [4] = '{32'h0000_0044, 32'h0000_AABB, 32'hFFFF_AABB, 32'hCAFE_F00D};

  task automatic cpu_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    bus_if.cpu_req      = req;
    bus_if.cpu_we       = we;
    bus_if.cpu_addr     = addr;
    bus_if.cpu_size     = size;
    bus_if.cpu_unsigned = uns;
    bus_if.cpu_wdata    = wdata;
  endtask

  task automatic ldr_set(input logic req, input logic we, input logic lock,
                         input logic [29:0] addr, input logic [31:0] wdata);
    bus_if.ldr_req   = req;
    bus_if.ldr_we    = we;
    bus_if.ldr_lock  = lock;
    bus_if.ldr_addr  = addr;
    bus_if.ldr_wdata = wdata;
  endtask

  task automatic test_reset();
    logic [172:0] outs;
    cpu_set(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    ldr_set(1'b1, 1'b0, 1'b0, 30'h3, 32'h0);
    bus_if.mem_read_data = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      #1;
      outs = {bus_if.cpu_gnt, bus_if.cpu_rvalid, bus_if.cpu_rdata, bus_if.cpu_misalign,
              bus_if.ldr_gnt, bus_if.ldr_rvalid, bus_if.ldr_rdata, bus_if.mem_read, bus_if.mem_write,
              bus_if.mem_address, bus_if.mem_maskByte, bus_if.mem_write_data};
      total++;
      if (outs !== '0) begin
        bad++;
        $display("FAIL reset_outputs[%0d] got=%h exp=0", k, outs);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    cpu_set(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    ldr_set(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
  endtask

  task automatic test_store_byte();
    @(negedge clk);
    cpu_set(1'b1, 1'b1, 32'h5, 2'b00, 1'b0, 32'hAB);
    #1;
    total++;
    if ({bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.mem_read, bus_if.mem_write, bus_if.mem_address,
         bus_if.mem_maskByte, bus_if.mem_write_data} !== {4'b1001, 30'h1, 4'b0010, 32'hAB}) begin
      bad++;
      $display("FAIL sb_port got gnt=%b wr=%b rd=%b addr=%h mask=%b wd=%h exp gnt=1 wr=1 rd=0 addr=1 mask=0010 wd=ab",
               bus_if.cpu_gnt, bus_if.mem_write, bus_if.mem_read, bus_if.mem_address, bus_if.mem_maskByte, bus_if.mem_write_data);
    end
    @(negedge clk);
    bus_if.cpu_req = 1'b0;
    #1;
    total++;
    if ({bus_if.cpu_rvalid, bus_if.mem_write, bus_if.mem_maskByte} !== 6'b0) begin
      bad++;
      $display("FAIL sb_after got rvalid=%b wr=%b mask=%b exp all 0", bus_if.cpu_rvalid, bus_if.mem_write, bus_if.mem_maskByte);
    end
  endtask

  task automatic test_loads();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_set(1'b1, 1'b0, ld_addr[i], ld_size[i], ld_uns[i], 32'h0);
      bus_if.mem_read_data = ld_word[i];
      #1;
      total++;
      if ({bus_if.cpu_gnt, bus_if.mem_read, bus_if.mem_write, bus_if.mem_address, bus_if.mem_maskByte} !==
          {3'b110, ld_addr[i][31:2], ld_mask[i]}) begin
        bad++;
        $display("FAIL load_port[%0d] got gnt=%b rd=%b wr=%b addr=%h mask=%b exp addr=%h mask=%b",
                 i, bus_if.cpu_gnt, bus_if.mem_read, bus_if.mem_write, bus_if.mem_address, bus_if.mem_maskByte,
                 ld_addr[i][31:2], ld_mask[i]);
      end
      @(negedge clk);
      bus_if.cpu_req = 1'b0;
      bus_if.mem_read_data = 32'h0;
      #1;
      total++;
      if ({bus_if.cpu_rvalid, bus_if.cpu_misalign, bus_if.cpu_rdata} !== {2'b10, ld_exp[i]}) begin
        bad++;
        $display("FAIL load_data[%0d] got rvalid=%b mis=%b rdata=%h exp rvalid=1 mis=0 rdata=%h",
                 i, bus_if.cpu_rvalid, bus_if.cpu_misalign, bus_if.cpu_rdata, ld_exp[i]);
      end
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_set(1'b1, ma_we[i], ma_addr[i], ma_size[i], 1'b0, 32'h5555);
      bus_if.mem_read_data = 32'hFFFF_FFFF;
      #1;
      total++;
      if ({bus_if.cpu_gnt, bus_if.mem_read, bus_if.mem_write, bus_if.mem_maskByte} !== 7'b1000000) begin
        bad++;
        $display("FAIL misalign_port[%0d] got gnt=%b rd=%b wr=%b mask=%b exp gnt=1 rd=0 wr=0 mask=0000",
                 i, bus_if.cpu_gnt, bus_if.mem_read, bus_if.mem_write, bus_if.mem_maskByte);
      end
      @(negedge clk);
      bus_if.cpu_req = 1'b0;
      #1;
      total++;
      if ({bus_if.cpu_rvalid, bus_if.cpu_misalign, bus_if.cpu_rdata} !== {2'b11, 32'h0}) begin
        bad++;
        $display("FAIL misalign_resp[%0d] got rvalid=%b mis=%b rdata=%h exp rvalid=1 mis=1 rdata=0",
                 i, bus_if.cpu_rvalid, bus_if.cpu_misalign, bus_if.cpu_rdata);
      end
    end
  endtask

  task automatic test_starvation();
    logic [3:0] exp;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cpu_set(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
        ldr_set(1'b1, 1'b0, 1'b0, 30'h155, 32'h0);
        bus_if.mem_read_data = 32'h1234_5678;
      end
      #1;
      exp = {(i != 4 && i != 9), (i == 4 || i == 9), (i == 5), (i != 0 && i != 5)};
      total++;
      if ({bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.ldr_rvalid, bus_if.cpu_rvalid} !== exp) begin
        bad++;
        $display("FAIL starve[%0d] got cgnt=%b lgnt=%b lrv=%b crv=%b exp %b",
                 i, bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.ldr_rvalid, bus_if.cpu_rvalid, exp);
      end
      if (i == 4) begin
        total++;
        if ({bus_if.mem_address, bus_if.mem_maskByte, bus_if.mem_read} !== {30'h155, 4'b1111, 1'b1}) begin
          bad++;
          $display("FAIL ldr_port got addr=%h mask=%b rd=%b exp addr=155 mask=1111 rd=1",
                   bus_if.mem_address, bus_if.mem_maskByte, bus_if.mem_read);
        end
      end
      if (i == 5) begin
        total++;
        if (bus_if.ldr_rdata !== 32'h1234_5678) begin
          bad++;
          $display("FAIL ldr_rdata got=%h exp=12345678", bus_if.ldr_rdata);
        end
      end
    end
    @(negedge clk);
    cpu_set(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    ldr_set(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    #1;
    total++;
    if ({bus_if.ldr_rvalid, bus_if.ldr_rdata, bus_if.cpu_rvalid} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      bad++;
      $display("FAIL starve_tail got lrv=%b lrd=%h crv=%b exp lrv=1 lrd=12345678 crv=0",
               bus_if.ldr_rvalid, bus_if.ldr_rdata, bus_if.cpu_rvalid);
    end
  endtask

  task automatic test_lock();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ldr_set(1'b1, 1'b1, 1'b1, 30'h10 + 30'(k), 32'hA0 + 32'(k));
      bus_if.cpu_req = (k != 0);
      bus_if.cpu_size = 2'b10;
      bus_if.cpu_addr = 32'h0;
      bus_if.cpu_we = 1'b0;
      #1;
      total++;
      if ({bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.mem_write, bus_if.mem_read, bus_if.mem_address,
           bus_if.mem_maskByte, bus_if.mem_write_data} !== {4'b0110, 30'h10 + 30'(k), 4'b1111, 32'hA0 + 32'(k)}) begin
        bad++;
        $display("FAIL lock_write[%0d] got cgnt=%b lgnt=%b wr=%b addr=%h mask=%b wd=%h",
                 k, bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.mem_write, bus_if.mem_address, bus_if.mem_maskByte, bus_if.mem_write_data);
      end
    end
    @(negedge clk);
    bus_if.ldr_req = 1'b0;
    #1;
    total++;
    if ({bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.mem_read, bus_if.mem_write, bus_if.ldr_rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL lock_idle got cgnt=%b lgnt=%b rd=%b wr=%b lrv=%b exp all 0",
               bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.mem_read, bus_if.mem_write, bus_if.ldr_rvalid);
    end
    @(negedge clk);
    bus_if.ldr_lock = 1'b0;
    bus_if.mem_read_data = 32'h0BAD_F00D;
    #1;
    total++;
    if ({bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.mem_read} !== 3'b101) begin
      bad++;
      $display("FAIL lock_release got cgnt=%b lgnt=%b rd=%b exp cgnt=1 lgnt=0 rd=1",
               bus_if.cpu_gnt, bus_if.ldr_gnt, bus_if.mem_read);
    end
    @(negedge clk);
    bus_if.cpu_req = 1'b0;
    #1;
    total++;
    if ({bus_if.cpu_rvalid, bus_if.cpu_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      bad++;
      $display("FAIL lock_after_load got rvalid=%b rdata=%h exp rvalid=1 rdata=0badf00d", bus_if.cpu_rvalid, bus_if.cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j < 4) begin
        cpu_set(1'b1, 1'b0, bb_addr[j], bb_size[j], bb_uns[j], 32'h0);
        bus_if.mem_read_data = bb_word[j];
      end else begin
        bus_if.cpu_req = 1'b0;
      end
      #1;
      if (j < 4) begin
        total++;
        if ({bus_if.cpu_gnt, bus_if.mem_read} !== 2'b11) begin
          bad++;
          $display("FAIL b2b_gnt[%0d] got gnt=%b rd=%b exp 1 1", j, bus_if.cpu_gnt, bus_if.mem_read);
        end
      end
      if (j > 0) begin
        total++;
        if ({bus_if.cpu_rvalid, bus_if.cpu_rdata} !== {1'b1, bb_exp[j-1]}) begin
          bad++;
          $display("FAIL b2b_data[%0d] got rvalid=%b rdata=%h exp rvalid=1 rdata=%h",
                   j - 1, bus_if.cpu_rvalid, bus_if.cpu_rdata, bb_exp[j-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cpu_set(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    bus_if.mem_read_data = 32'h5555_AAAA;
    #1;
    total++;
    if (bus_if.cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_gnt got=%b exp=1", bus_if.cpu_gnt);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      #1;
      total++;
      if ({bus_if.cpu_rvalid, bus_if.cpu_rdata, bus_if.cpu_gnt, bus_if.mem_read, bus_if.mem_address} !== '0) begin
        bad++;
        $display("FAIL rstmid[%0d] got rvalid=%b rdata=%h gnt=%b rd=%b addr=%h exp all 0",
                 k, bus_if.cpu_rvalid, bus_if.cpu_rdata, bus_if.cpu_gnt, bus_if.mem_read, bus_if.mem_address);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus_if.cpu_req = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (bus_if.cpu_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_release got rvalid=%b exp=0", bus_if.cpu_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_misalign();
    test_starvation();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
